cfi_landing_pad_checker: RTL
============================

CFI_LANDING_PAD_CHECKER -- requirements
Module: cfi_landing_pad_checker

Interface
REQ-001 NR_PORTS, default NR_COMMIT_PORTS (2), number of commit ports monitored; legal range 1..4.
REQ-002 CNT_W, default 8, width of the violation and landing-pad counters.
REQ-003 CHECK_CALLS, default 0: 0 = check returns only; 1 = also check indirect calls.
REQ-004 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 commit_instr_i  in  scoreboard_entry_t[NR_PORTS]  committing instruction per port (fields op, fu, rs1, rd, result).
REQ-007 commit_ack_i  in  NR_PORTS  port i commits this cycle; acks are contiguous from port 0.
REQ-008 enable_i  in  1  checker active.
REQ-009 flush_i  in  1  pipeline flush/exception; drops any pending check.
REQ-010 clear_i  in  1  synchronous clear of counters and sticky flag.
REQ-011 armed_o  out  1  a landing pad is currently expected.
REQ-012 violation_o  out  1  one-cycle pulse, at least one violation in the previous commit cycle.
REQ-013 sticky_o  out  1  a violation has occurred since reset/clear.
REQ-014 viol_cnt_o  out  CNT_W  saturating violation count.
REQ-015 lp_cnt_o  out  CNT_W  saturating count of landing pads that satisfied a pending check.

Function
REQ-016 Return: op==JALR, rd==x0, rs1==x1.
REQ-017 Indirect call, counted only when CHECK_CALLS=1: op==JALR, rd==x1.
REQ-018 Landing pad: op==ADD, fu==ALU, rd==x0, rs1==x1, result[31:0]==32'h3.
REQ-019 FSM states: IDLE (no pad expected), ARMED (pad expected), ALERT (one-cycle report state).
REQ-020 Per cycle, the acked ports are evaluated in order 0..NR_PORTS-1 with pending flag p, which starts at 1 if the state is ARMED and 0 otherwise.
REQ-021 Per port, when p=1: a landing pad adds one to the hit count; any other instruction adds one to the violation count; either way p is cleared.
REQ-022 Per port, after the check in REQ-021: a checked transfer (REQ-016/017) sets p=1.
REQ-023 A return that is itself the violating instruction re-arms; a violation and a re-arm can occur on the same port.
REQ-024 A return on port i and a landing pad on port i+1 in the same cycle is a hit, not a violation.
REQ-025 Ports with commit_ack_i=0 are ignored; a cycle with no acks leaves p and the state unchanged.
REQ-026 Next state is ALERT if the cycle's violation count is >0; otherwise ARMED if final p=1; otherwise IDLE.
REQ-027 ALERT is transparent: it evaluates commits like IDLE/ARMED, using the p carried from the alerting cycle.
REQ-028 To carry that p, the pending flag is a separate register, and armed_o equals that register.
REQ-029 violation_o = 1 exactly while the state is ALERT; sticky_o is set in the same cycle and held.
REQ-030 Counters add the per-cycle totals (0..NR_PORTS) and saturate at 2^CNT_W-1, with no wrap.
REQ-031 All outputs are registered; results of a commit cycle are visible one clock later.
REQ-032 flush_i=1: p register cleared, state forced to IDLE, and that cycle's commits are not evaluated.
REQ-033 enable_i=0: no evaluation and p cleared; counters and sticky hold.
REQ-034 clear_i=1: counters and sticky_o zeroed; events in that cycle are discarded for the counters.
REQ-035 clear_i=1 does not affect the FSM or p.
REQ-036 Priority when several controls are active in one cycle: flush_i > enable_i=0 > normal evaluation.

Reset
REQ-037 While rst_i=1, asynchronously: state IDLE, p=0, armed_o=0, violation_o=0, sticky_o=0, viol_cnt_o=0, lp_cnt_o=0.
REQ-038 Reset asserted mid-check discards the pending check; the first cycle after release evaluates from IDLE.

Verification
REQ-039 Cycle 1: return on port0 (ack=01); cycle 2: pad on port0 -> armed_o=1 after cycle 1, then 0; lp_cnt_o=1, violation_o never 1.
REQ-040 Return on port0 and pad on port1 in one cycle (ack=11) -> lp_cnt_o=1, armed_o=0, viol_cnt_o=0.
REQ-041 Return on port0; next cycle ADD x5 on port0 -> violation_o=1 for exactly one cycle; viol_cnt_o=1; sticky_o=1 and stays 1.
REQ-042 Two returns each followed by a non-pad within one cycle (NR_PORTS=4, ack=1111) -> viol_cnt_o increases by 2, one violation_o pulse.
REQ-043 CNT_W=2, six violations -> viol_cnt_o saturates at 3; then clear_i -> 0, sticky_o=0.
REQ-044 Return, then flush_i, then non-pad commit -> no violation; reset asserted while ARMED -> all outputs 0 immediately.

Source files
------------

// File: rtl/cfi_landing_pad_checker.sv
// ---------------------------------------------------------------------------
// cfi_landing_pad_checker
//
// Purpose: forward/backward-edge control-flow-integrity monitor on the commit
// stream. After a checked control transfer (a return, and optionally an
// indirect call) the very next committed instruction must be a landing pad
// (ADD x0, x1, ... producing 3 on the ALU). Anything else is a violation.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   commit_instr_i committing instruction per port (packed, port 0 = LSB)
//   commit_ack_i   per-port commit strobe, contiguous from port 0
//   enable_i       checker active; when low nothing is evaluated, pad expectation dropped
//   flush_i        pipeline flush/exception; drops pending check, skips the cycle
//   clear_i        synchronous clear of counters and sticky flag
//   armed_o        a landing pad is expected next
//   violation_o    one-cycle pulse after a commit cycle with >=1 violation
//   sticky_o       violation seen since reset/clear
//   viol_cnt_o     saturating violation count
//   lp_cnt_o       saturating count of landing pads that satisfied a check
// ---------------------------------------------------------------------------
package cfi_lp_pkg;
  localparam int unsigned NR_COMMIT_PORTS = 2;

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_SUB  = 8'd1;
  localparam logic [7:0] OP_JALR = 8'd2;
  localparam logic [7:0] OP_LOAD = 8'd3;

  localparam logic [3:0] FU_NONE = 4'd0;
  localparam logic [3:0] FU_ALU  = 4'd1;
  localparam logic [3:0] FU_CTRL = 4'd2;
  localparam logic [3:0] FU_LSU  = 4'd3;

  typedef struct packed {
    logic [7:0]  op;
    logic [3:0]  fu;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [63:0] result;
  } scoreboard_entry_t;
endpackage

module cfi_landing_pad_checker
  import cfi_lp_pkg::*;
#(
  parameter int unsigned NR_PORTS    = NR_COMMIT_PORTS,
  parameter int unsigned CNT_W       = 8,
  parameter bit          CHECK_CALLS = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  scoreboard_entry_t [NR_PORTS-1:0] commit_instr_i,
  input  logic [NR_PORTS-1:0]              commit_ack_i,
  input  logic                             enable_i,
  input  logic                             flush_i,
  input  logic                             clear_i,
  output logic                             armed_o,
  output logic                             violation_o,
  output logic                             sticky_o,
  output logic [CNT_W-1:0]                 viol_cnt_o,
  output logic [CNT_W-1:0]                 lp_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ALERT = 2'd2
  } state_e;

  state_e           state_r, state_next_s;
  logic             pend_r, pend_next_s, pend_walk_s;
  logic [2:0]       hit_cnt_s, viol_cycle_s;
  logic             violation_r, violation_next_s;
  logic             sticky_r, sticky_next_s;
  logic [CNT_W-1:0] viol_cnt_r, viol_cnt_next_s;
  logic [CNT_W-1:0] lp_cnt_r, lp_cnt_next_s;
  logic             unused_result_s;

  function automatic logic is_return(input scoreboard_entry_t e);
    return (e.op == OP_JALR) && (e.rd == 5'd0) && (e.rs1 == 5'd1);
  endfunction

  function automatic logic is_call(input scoreboard_entry_t e);
    return (e.op == OP_JALR) && (e.rd == 5'd1);
  endfunction

  function automatic logic is_landing_pad(input scoreboard_entry_t e);
    return (e.op == OP_ADD) && (e.fu == FU_ALU) && (e.rd == 5'd0) &&
           (e.rs1 == 5'd1) && (e.result[31:0] == 32'h0000_0003);
  endfunction

  function automatic logic is_checked_xfer(input scoreboard_entry_t e);
    return is_return(e) || (CHECK_CALLS && is_call(e));
  endfunction

  // Add a per-cycle event total without wrapping past all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [2:0]       inc);
    logic [CNT_W+2:0] sum;
    sum = {3'b000, cnt} + {{CNT_W{1'b0}}, inc};
    if (sum[CNT_W+2:CNT_W] != 3'b000) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Only the low 32 result bits identify a pad; fold the rest away.
  always_comb begin
    unused_result_s = 1'b0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      unused_result_s = unused_result_s ^ (^commit_instr_i[i].result[63:32]);
    end
  end

  // State and pending-pad registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pend_r  <= pend_next_s;
    end
  end

  // Walk the acked ports in order, tallying hits/violations and the next state.
  // The walk starts from pend_r rather than the state so that a cycle spent in
  // ALERT still carries the expectation raised by the alerting cycle.
  always_comb begin
    pend_walk_s  = pend_r;
    pend_next_s  = pend_r;
    hit_cnt_s    = 3'd0;
    viol_cycle_s = 3'd0;
    state_next_s = state_r;
    if (flush_i) begin
      pend_next_s  = 1'b0;
      state_next_s = ST_IDLE;
    end else if (!enable_i) begin
      pend_next_s  = 1'b0;
      state_next_s = ST_IDLE;
    end else begin
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
        if (commit_ack_i[i]) begin
          if (pend_walk_s) begin
            if (is_landing_pad(commit_instr_i[i])) begin
              hit_cnt_s = hit_cnt_s + 3'd1;
            end else begin
              viol_cycle_s = viol_cycle_s + 3'd1;
            end
          end else begin
            hit_cnt_s = hit_cnt_s;
          end
          // Check first, then re-arm: a violating return still expects a pad.
          if (is_checked_xfer(commit_instr_i[i])) begin
            pend_walk_s = 1'b1;
          end else begin
            pend_walk_s = 1'b0;
          end
        end else begin
          pend_walk_s = pend_walk_s;
        end
      end
      pend_next_s = pend_walk_s;
      // With no acks this leaves IDLE/ARMED unchanged and retires ALERT.
      if (viol_cycle_s != 3'd0) begin
        state_next_s = ST_ALERT;
      end else if (pend_walk_s) begin
        state_next_s = ST_ARMED;
      end else begin
        state_next_s = ST_IDLE;
      end
    end
  end

  // Next values of the reported flags and counters.
  always_comb begin
    violation_next_s = 1'b0;
    sticky_next_s    = sticky_r;
    viol_cnt_next_s  = viol_cnt_r;
    lp_cnt_next_s    = lp_cnt_r;
    case (state_next_s)
      ST_ALERT: violation_next_s = 1'b1;
      ST_IDLE,
      ST_ARMED: violation_next_s = 1'b0;
      default:  violation_next_s = 1'b0;
    endcase
    if (clear_i) begin
      sticky_next_s   = 1'b0;
      viol_cnt_next_s = {CNT_W{1'b0}};
      lp_cnt_next_s   = {CNT_W{1'b0}};
    end else begin
      sticky_next_s   = sticky_r | (viol_cycle_s != 3'd0);
      viol_cnt_next_s = sat_add(viol_cnt_r, viol_cycle_s);
      lp_cnt_next_s   = sat_add(lp_cnt_r, hit_cnt_s);
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      violation_r <= 1'b0;
      sticky_r    <= 1'b0;
      viol_cnt_r  <= {CNT_W{1'b0}};
      lp_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      violation_r <= violation_next_s;
      sticky_r    <= sticky_next_s;
      viol_cnt_r  <= viol_cnt_next_s;
      lp_cnt_r    <= lp_cnt_next_s;
    end
  end

  assign armed_o     = pend_r;
  assign violation_o = violation_r;
  assign sticky_o    = sticky_r;
  assign viol_cnt_o  = viol_cnt_r;
  assign lp_cnt_o    = lp_cnt_r;

endmodule
